// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front-end fetch stage. Owns the program counter, runs the variable-latency
// instruction memory handshake and loads the IF/ID register. It reports to the
// stall logic whether it is waiting on memory and obeys the stall it gets back.
// Branch redirects flush IF/ID and discard any fetch still in flight.
//
// Ports
//   clk                         rising-edge clock
//   reset                       asynchronous, active-low
//   isPipelineStalled           hold PC and IF/ID (from stall logic)
//   isBranchTaken               redirect request from the execution stage
//   branchTargetAddress[31:0]   redirect PC, bits [1:0] forced to 0
//   instructionMemoryRequest    fetch request level
//   instructionMemoryAddress    fetch address, stable while request is high
//   instructionMemoryDataValid  one-cycle response strobe per request
//   instructionMemoryData       instruction word, sampled with the strobe
//   isInstructionMemoryBlocked  fetch cannot supply an instruction this cycle
//   decodeStageInstruction      IF/ID instruction
//   decodeStageProgramCounter   IF/ID PC
//   decodeStageValid            IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        isPipelineStalled,
    input  logic        isBranchTaken,
    input  logic [31:0] branchTargetAddress,
    output logic        instructionMemoryRequest,
    output logic [31:0] instructionMemoryAddress,
    input  logic        instructionMemoryDataValid,
    input  logic [31:0] instructionMemoryData,
    output logic        isInstructionMemoryBlocked,
    output logic [31:0] decodeStageInstruction,
    output logic [31:0] decodeStageProgramCounter,
    output logic        decodeStageValid
);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        FETCHING,
        BUFFERED,
        DRAIN
    } fetchState_t;

    fetchState_t state;
    logic [31:0] pc;
    logic [31:0] drainAddress;
    logic [31:0] buffer;
    logic [31:0] branchTarget;

    // Sequential PC step; wraps naturally modulo 2^32.
    function automatic logic [31:0] nextSequentialPc(input logic [31:0] current);
        return (current + 32'd4) & WORD_MASK;
    endfunction

    assign branchTarget = branchTargetAddress & WORD_MASK;

    // In DRAIN the memory still owns the pre-redirect address, so it must be
    // held even though pc already points at the branch target.
    assign instructionMemoryAddress = (state == DRAIN) ? drainAddress : pc;

    // Depends only on state and the memory strobe, never on the stall input,
    // so the loop through the stall logic stays purely sequential.
    always_comb begin
        isInstructionMemoryBlocked = 1'b1;
        case (state)
            IDLE:     isInstructionMemoryBlocked = 1'b1;
            FETCHING: isInstructionMemoryBlocked = !instructionMemoryDataValid;
            BUFFERED: isInstructionMemoryBlocked = 1'b0;
            DRAIN:    isInstructionMemoryBlocked = 1'b1;
            default:  isInstructionMemoryBlocked = 1'b1;
        endcase
    end

    // Fetch / IF-ID stage boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                     <= IDLE;
            pc                        <= RESET_PC & WORD_MASK;
            drainAddress              <= '0;
            buffer                    <= '0;
            instructionMemoryRequest  <= 1'b0;
            decodeStageInstruction    <= NOP_INSTRUCTION;
            decodeStageProgramCounter <= '0;
            decodeStageValid          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (isBranchTaken) begin
                        pc <= branchTarget;
                    end
                    state                    <= FETCHING;
                    instructionMemoryRequest <= 1'b1;
                end

                FETCHING: begin
                    if (isBranchTaken) begin
                        // Redirect wins over everything; the response (if any)
                        // this cycle belongs to the wrong path.
                        pc                        <= branchTarget;
                        decodeStageInstruction    <= NOP_INSTRUCTION;
                        decodeStageProgramCounter <= '0;
                        decodeStageValid          <= 1'b0;
                        if (!instructionMemoryDataValid) begin
                            // Outstanding request must complete before a new
                            // address can be issued.
                            drainAddress <= pc;
                            state        <= DRAIN;
                        end
                    end else if (instructionMemoryDataValid) begin
                        if (!isPipelineStalled) begin
                            decodeStageInstruction    <= instructionMemoryData;
                            decodeStageProgramCounter <= pc;
                            decodeStageValid          <= 1'b1;
                            pc                        <= nextSequentialPc(pc);
                        end else begin
                            // Memory cannot be back-pressured, so park the word.
                            buffer                   <= instructionMemoryData;
                            state                    <= BUFFERED;
                            instructionMemoryRequest <= 1'b0;
                        end
                    end
                end

                BUFFERED: begin
                    if (isBranchTaken) begin
                        pc                        <= branchTarget;
                        decodeStageInstruction    <= NOP_INSTRUCTION;
                        decodeStageProgramCounter <= '0;
                        decodeStageValid          <= 1'b0;
                        state                     <= FETCHING;
                        instructionMemoryRequest  <= 1'b1;
                    end else if (!isPipelineStalled) begin
                        decodeStageInstruction    <= buffer;
                        decodeStageProgramCounter <= pc;
                        decodeStageValid          <= 1'b1;
                        pc                        <= nextSequentialPc(pc);
                        state                     <= FETCHING;
                        instructionMemoryRequest  <= 1'b1;
                    end
                end

                DRAIN: begin
                    // IF/ID was flushed on entry; only pc tracks new redirects.
                    if (isBranchTaken) begin
                        pc <= branchTarget;
                    end
                    if (instructionMemoryDataValid) begin
                        state <= FETCHING;
                    end
                end

                default: begin
                    state                    <= IDLE;
                    instructionMemoryRequest <= 1'b0;
                end
            endcase
        end
    end

endmodule
